// File: rtl/uart_pkg.sv
// Shared UART constants and helpers used by the baud generator and its counters.
package uart_pkg;

   localparam int UART_DIV_WIDTH  = 32;
   localparam int UART_OVERSAMPLE = 16;

   // Width of a counter that must hold 0..oversample-1.
   function automatic int os_cnt_width(input int oversample);
      return (oversample > 1) ? $clog2(oversample) : 1;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter: counts 0..max_i with synchronous clear, advance enable and a
// combinational pulse on the step that wraps back to 0.
module mod_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             arst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] max_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: defaults first, so every path assigns every output and no latch is inferred.
      cnt_d  = cnt_q;
      wrap_o = 1'b0;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == max_i) begin
            cnt_d  = '0;
            wrap_o = 1'b1;
         end else begin
            cnt_d = cnt_q + WIDTH'(1);
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: divides clk_i into oversample ticks, then derives bit-boundary
// and bit-midpoint ticks; the divisor is shadowed so a change only lands at a tick.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH  = UART_DIV_WIDTH,
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic                 clk_i,
   input  logic                 arst_ni,
   input  logic                 en_i,
   input  logic                 restart_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 os_tick_o,
   output logic                 bit_tick_o,
   output logic                 mid_tick_o,
   output logic [DIV_WIDTH-1:0] div_active_o
);

   localparam int              OS_W       = os_cnt_width(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST    = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_PRE_MID = OS_W'(OVERSAMPLE / 2 - 1);

   logic [DIV_WIDTH-1:0] div_q, div_d, div_eff;
   logic                 run_q, run_d;
   logic                 os_tick_q, os_tick_d;
   logic                 bit_tick_q, bit_tick_d;
   logic                 mid_tick_q, mid_tick_d;
   logic                 load_pre, cnt_en, cyc_wrap, os_wrap;
   logic [DIV_WIDTH-1:0] cyc_cnt_unused;
   logic [OS_W-1:0]      os_cnt;

   // A period only advances once the generator has been running for one edge with a
   // settled divisor; every other enabled edge acts as a phase restart.
   always_comb begin
      load_pre   = !en_i || restart_i || (div_q == '0);
      div_eff    = load_pre ? div_i : div_q;
      run_d      = en_i && (div_eff != '0);
      cnt_en     = run_q && !load_pre;
      div_d      = (load_pre || cyc_wrap) ? div_i : div_q;
      os_tick_d  = cyc_wrap;
      bit_tick_d = os_wrap;
      mid_tick_d = cyc_wrap && (os_cnt == OS_PRE_MID);
   end

   mod_counter #(
      .WIDTH (DIV_WIDTH)
   ) u_cyc_cnt (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .clr_i   (!cnt_en),
      .en_i    (cnt_en),
      .max_i   (div_q - DIV_WIDTH'(1)),
      .cnt_o   (cyc_cnt_unused),
      .wrap_o  (cyc_wrap)
   );

   mod_counter #(
      .WIDTH (OS_W)
   ) u_os_cnt (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .clr_i   (!cnt_en),
      .en_i    (cyc_wrap),
      .max_i   (OS_LAST),
      .cnt_o   (os_cnt),
      .wrap_o  (os_wrap)
   );

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         div_q      <= '0;
         run_q      <= 1'b0;
         os_tick_q  <= 1'b0;
         bit_tick_q <= 1'b0;
         mid_tick_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         run_q      <= run_d;
         os_tick_q  <= os_tick_d;
         bit_tick_q <= bit_tick_d;
         mid_tick_q <= mid_tick_d;
      end
   end

   assign os_tick_o    = os_tick_q;
   assign bit_tick_o   = bit_tick_q;
   assign mid_tick_o   = mid_tick_q;
   assign div_active_o = div_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: directed scenarios followed by random stimulus, all checked
// every cycle against an absolute-time model of when the next tick is due.
module tb_uart_baud_gen;

   logic        clk;
   logic        arst_n;
   logic        en;
   logic        restart;
   logic [31:0] div;
   logic        os_tick, bit_tick, mid_tick;
   logic [31:0] div_active;

   int     vectors     = 0;
   int     miscompares = 0;
   longint cyc         = 0;
   longint e0          = 0;
   int     tq[$];
   int     first_mid   = -1;
   int     first_bit   = -1;

   // Reference model: the next tick is scheduled at an absolute edge index.
   bit          m_running;
   logic [31:0] m_div;
   longint      m_next;
   int          m_nticks;
   bit          m_os, m_bit, m_mid;

   uart_baud_gen dut (
      .clk_i        (clk),
      .arst_ni      (arst_n),
      .en_i         (en),
      .restart_i    (restart),
      .div_i        (div),
      .os_tick_o    (os_tick),
      .bit_tick_o   (bit_tick),
      .mid_tick_o   (mid_tick),
      .div_active_o (div_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_running = 1'b0;
      m_div     = '0;
      m_next    = 0;
      m_nticks  = 0;
      m_os      = 1'b0;
      m_bit     = 1'b0;
      m_mid     = 1'b0;
   endtask

   task automatic model_edge();
      m_os  = 1'b0;
      m_bit = 1'b0;
      m_mid = 1'b0;
      if (!en) begin
         m_running = 1'b0;
         m_div     = div;
         m_nticks  = 0;
      end else if (restart || !m_running || m_div == 0) begin
         if (restart || m_div == 0) m_div = div;
         m_nticks  = 0;
         m_running = (m_div != 0);
         m_next    = cyc + longint'(m_div);
      end else if (cyc == m_next) begin
         m_os     = 1'b1;
         m_nticks = m_nticks + 1;
         m_mid    = (m_nticks % 16 == 8);
         m_bit    = (m_nticks % 16 == 0);
         m_div    = div;
         m_next   = cyc + longint'(div);
      end
   endtask

   task automatic mark();
      e0 = cyc;
      tq.delete();
      first_mid = -1;
      first_bit = -1;
   endtask

   task automatic step();
      int rel;
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      check_val("os_tick", os_tick, m_os);
      check_val("bit_tick", bit_tick, m_bit);
      check_val("mid_tick", mid_tick, m_mid);
      check_val("div_active", div_active, m_div);
      rel = int'(cyc - 1 - e0);
      if (os_tick) tq.push_back(rel);
      if (mid_tick && first_mid < 0) first_mid = rel;
      if (bit_tick && first_bit < 0) first_bit = rel;
   endtask

   task automatic check_ticks(input string tag, input int exp_q[$]);
      check_val({tag, "_count"}, tq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check_val(tag, (i < tq.size()) ? tq[i] : -1, exp_q[i]);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_os"}, os_tick, 0);
      check_val({tag, "_bit"}, bit_tick, 0);
      check_val({tag, "_mid"}, mid_tick, 0);
      check_val({tag, "_div"}, div_active, 0);
   endtask

   initial begin
      int exp_q[$];
      arst_n  = 1'b1;
      en      = 1'b0;
      restart = 1'b0;
      div     = 32'd3;
      model_reset();

      // Reset state, then div=3 straight out of reset.
      #1 arst_n = 1'b0;
      #1 check_all_zero("reset");
      @(negedge clk);
      #2 arst_n = 1'b1;
      en = 1'b1;
      mark();
      repeat (50) step();
      exp_q.delete();
      for (int k = 1; k <= 16; k++) exp_q.push_back(3 * k);
      check_ticks("div3_ticks", exp_q);
      check_val("div3_first_mid", first_mid, 24);
      check_val("div3_first_bit", first_bit, 48);

      // Divisor 10 -> 4 in the middle of a period.
      en = 1'b0; div = 32'd10; step();
      en = 1'b1;
      mark();
      for (int k = 0; k <= 30; k++) begin
         if (k == 16) div = 32'd4;
         step();
         if (k == 19) check_val("div_hold", div_active, 10);
         if (k == 20) check_val("div_switch", div_active, 4);
      end
      exp_q = '{10, 20, 24, 28};
      check_ticks("div_change_ticks", exp_q);

      // Divisor 1 gives a tick every cycle; divisor 0 stops everything.
      en = 1'b0; div = 32'd1; step();
      en = 1'b1;
      mark();
      repeat (21) step();
      exp_q.delete();
      for (int k = 1; k <= 20; k++) exp_q.push_back(k);
      check_ticks("div1_ticks", exp_q);
      div = 32'd0;
      step();
      step();
      mark();
      repeat (100) begin
         step();
         check_val("div0_cyc_cnt", dut.u_cyc_cnt.cnt_q, 0);
         check_val("div0_os_cnt", 32'(dut.u_os_cnt.cnt_q), 0);
      end
      exp_q.delete();
      check_ticks("div0_ticks", exp_q);

      // Restart on the edge a tick is due.
      en = 1'b0; div = 32'd5; step();
      en = 1'b1;
      mark();
      for (int k = 0; k <= 25; k++) begin
         restart = (k == 15);
         step();
         if (k == 15) check_val("restart_os_cnt", 32'(dut.u_os_cnt.cnt_q), 0);
      end
      restart = 1'b0;
      exp_q = '{5, 10, 20, 25};
      check_ticks("restart_ticks", exp_q);

      // Enable dropped mid-bit, re-enabled 3 cycles later with div=2.
      en = 1'b0; div = 32'd2; step();
      en = 1'b1;
      repeat (7) step();
      en = 1'b0;
      mark();
      repeat (3) step();
      exp_q.delete();
      check_ticks("en_low_ticks", exp_q);
      en = 1'b1;
      mark();
      repeat (20) step();
      exp_q.delete();
      for (int k = 1; k <= 9; k++) exp_q.push_back(2 * k);
      check_ticks("reenable_ticks", exp_q);
      check_val("reenable_first_mid", first_mid, 16);

      // Asynchronous reset in the middle of a div=7 period.
      en = 1'b0; div = 32'd7; step();
      en = 1'b1;
      repeat (10) step();
      #2 arst_n = 1'b0;
      #1 check_all_zero("async_reset");
      check_val("async_reset_cyc_cnt", dut.u_cyc_cnt.cnt_q, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      #2 arst_n = 1'b1;
      mark();
      repeat (12) step();
      exp_q = '{7};
      check_ticks("post_reset_ticks", exp_q);

      // Random enables, restarts and divisor changes against the model.
      mark();
      repeat (700) begin
         en      = ($urandom_range(0, 63) != 0);
         restart = ($urandom_range(0, 127) == 0);
         if ($urandom_range(0, 15) == 0) div = 32'($urandom_range(0, 6));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
